// File: rtl/fetch_decode_if.sv
// Handshake and register-file control bundle for fetch_decode.
// master = the sequencer (fetch_decode), slave = instruction memory / datapath side.
interface fetch_decode_if #(
  parameter int unsigned W   = 8,
  parameter int unsigned A   = 2,
  parameter int unsigned PCW = 10,
  parameter int unsigned IW  = 9
);
  logic           Start;
  logic           InstrReq;
  logic [PCW-1:0] PC;
  logic [IW-1:0]  InstrIn;
  logic           InstrValid;
  logic [W-1:0]   JumpReg;
  logic           BranchTaken;
  logic [A-1:0]   RaddrA;
  logic [A-1:0]   RaddrB;
  logic [A-1:0]   Waddr;
  logic           WriteEn;
  logic           Jump;
  logic           SetInst;
  logic           LUT2x;
  logic [W-1:0]   Imm;
  logic [3:0]     LutIdx;
  logic           Done;
  logic [15:0]    InstrCount;

  modport master (
    input  Start, InstrIn, InstrValid, JumpReg, BranchTaken,
    output InstrReq, PC, RaddrA, RaddrB, Waddr, WriteEn, Jump, SetInst, LUT2x,
           Imm, LutIdx, Done, InstrCount
  );

  modport slave (
    output Start, InstrIn, InstrValid, JumpReg, BranchTaken,
    input  InstrReq, PC, RaddrA, RaddrB, Waddr, WriteEn, Jump, SetInst, LUT2x,
           Imm, LutIdx, Done, InstrCount
  );
endinterface

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode sequencer: IDLE -> FETCH -> DECODE -> EXEC -> (FETCH | HALT).
// Optional retired-instruction counter enabled by macro FETCH_INSTR_COUNT_EN.
module fetch_decode #(
  parameter int unsigned W   = 8,
  parameter int unsigned A   = 2,
  parameter int unsigned PCW = 10,
  parameter int unsigned IW  = 9
) (
  input  logic            Clk,
  input  logic            Reset,
  fetch_decode_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  localparam logic [2:0] OpAlu  = 3'd0;
  localparam logic [2:0] OpSet  = 3'd1;
  localparam logic [2:0] OpLut  = 3'd2;
  localparam logic [2:0] OpJmp  = 3'd3;
  localparam logic [2:0] OpHalt = 3'd7;

  state_e         r_state;
  state_e         w_state_next;
  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] w_pc_next;
  logic [IW-1:0]  r_instr;
  logic [IW-1:0]  w_instr_next;
  logic [2:0]     w_opcode;
  logic           w_start_accept;
  logic           w_exec;

  assign w_opcode = r_instr[8:6];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_instr_next   = r_instr;
    w_start_accept = 1'b0;
    w_exec         = 1'b0;
    unique case (r_state)
      StIdle, StHalt: begin
        if (bus.Start) begin
          w_start_accept = 1'b1;
          w_state_next   = StFetch;
          w_pc_next      = '0;
        end
      end
      StFetch: begin
        if (bus.InstrValid) begin
          w_instr_next = bus.InstrIn;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        w_state_next = StExec;
      end
      StExec: begin
        w_exec = 1'b1;
        // Only a taken JMP redirects; every other opcode (HALT included) steps PC, wrapping.
        if (w_opcode == OpJmp && bus.BranchTaken) begin
          w_pc_next = PCW'(bus.JumpReg);
        end else begin
          w_pc_next = r_pc + PCW'(1);
        end
        w_state_next = (w_opcode == OpHalt) ? StHalt : StFetch;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.InstrReq = (r_state == StFetch);
    bus.PC       = r_pc;
    bus.Done     = (r_state == StHalt);
    bus.RaddrA   = '0;
    bus.RaddrB   = '0;
    bus.Waddr    = '0;
    bus.Imm      = '0;
    bus.LutIdx   = '0;
    bus.WriteEn  = 1'b0;
    bus.Jump     = 1'b0;
    bus.SetInst  = 1'b0;
    bus.LUT2x    = 1'b0;
    if (r_state == StDecode || r_state == StExec) begin
      bus.RaddrA = A'(r_instr[5:4]);
      bus.RaddrB = A'(r_instr[3:2]);
      bus.Waddr  = A'(r_instr[5:4]);
      bus.Imm    = W'(r_instr[5:0]);
      bus.LutIdx = r_instr[3:0];
    end
    if (r_state == StExec) begin
      case (w_opcode)
        OpAlu: bus.WriteEn = 1'b1;
        OpSet: begin
          bus.SetInst = 1'b1;
          bus.WriteEn = 1'b1;
        end
        OpLut:   bus.LUT2x = 1'b1;
        OpJmp:   bus.Jump  = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_instr_count <= '0;
    end else if (w_start_accept) begin
      r_instr_count <= '0;
    end else if (w_exec) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign bus.InstrCount = r_instr_count;
`else
  logic w_unused_cnt;
  assign w_unused_cnt   = w_start_accept ^ w_exec;
  assign bus.InstrCount = '0;
`endif

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameters: W=8, register data width; A=2, register address width; PCW=10, program counter width; IW=9, instruction width.
REQ-002 SHALL have ports: Clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: Reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports: Start  in  1  begin execution at PC=0 from IDLE or HALT.
REQ-005 SHALL have ports: InstrReq  out  1  instruction fetch request; PC  out  PCW  fetch address.
REQ-006 SHALL have ports: InstrIn  in  IW  instruction word; InstrValid  in  1  InstrIn valid this cycle.
REQ-007 SHALL have ports: JumpReg  in  W  jump target from register file; BranchTaken  in  1  ALU branch condition.
REQ-008 SHALL have ports: RaddrA, RaddrB, Waddr  out  A  register file addresses.
REQ-009 SHALL have ports: WriteEn, Jump, SetInst, LUT2x  out  1  register file control strobes.
REQ-010 SHALL have ports: Imm  out  W  zero-extended InstrIn[5:0]; LutIdx  out  4  InstrIn[3:0]; Done  out  1  halted.
REQ-011 SHALL have port InstrCount  out  16  retired-instruction count (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-013 SHALL transition IDLE->FETCH and HALT->FETCH on Start=1, loading PC=0.
REQ-014 SHALL assert InstrReq=1 only in FETCH; on InstrReq&InstrValid, SHALL latch InstrIn and go to DECODE; otherwise SHALL stay in FETCH indefinitely.
REQ-015 SHALL go DECODE->EXEC unconditionally; EXEC->FETCH for non-HALT opcodes; EXEC->HALT for HALT.
REQ-016 SHALL drive addresses from the latched instruction in DECODE and EXEC; control strobes SHALL be high only in EXEC, for exactly one cycle.
REQ-017 SHALL decode opcode = instr[8:6] as follows.
REQ-018 Opcode 0 (ALU) SHALL drive WriteEn=1, Waddr=RaddrA=instr[5:4], RaddrB=instr[3:2].
REQ-019 Opcode 1 (SET) SHALL drive SetInst=1, WriteEn=1, Waddr=instr[5:4], Imm={0,instr[5:0]}.
REQ-020 Opcode 2 (LUT) SHALL drive LUT2x=1, WriteEn=0, Waddr=instr[5:4], LutIdx=instr[3:0].
REQ-021 Opcode 3 (JMP) SHALL drive Jump=1, WriteEn=0; on the EXEC edge, PC SHALL load zero-extended JumpReg if BranchTaken=1, else PC+1.
REQ-022 Opcode 7 (HALT) SHALL assert no strobes; opcodes 4-6 SHALL be NOPs (PC+1, no strobes).
REQ-023 Non-jump EXEC SHALL set PC=PC+1 modulo 2^PCW (1023 wraps to 0).
REQ-024 Done SHALL be 1 only in HALT; Start SHALL be ignored in FETCH, DECODE and EXEC.
REQ-025 Latency: the handshake edge is followed by one DECODE cycle, then one EXEC cycle; the next InstrReq follows EXEC.

Reset
REQ-026 Reset=0 SHALL immediately force state IDLE, PC=0, latched instruction=0, and all outputs to 0, including InstrCount; an in-flight fetch SHALL be discarded.
REQ-027 After Reset deasserts, the block SHALL remain in IDLE until Start=1.

Configuration
REQ-028 With macro FETCH_INSTR_COUNT_EN defined, InstrCount SHALL increment by 1 (wrapping) on every EXEC cycle and SHALL clear on Start; without it, InstrCount SHALL be constant 0 and no counter SHALL be synthesized.

Verification
REQ-029 Reset=0 mid-FETCH with InstrReq=1 -> outputs all 0 and state IDLE immediately; release, Start=1 -> next cycle InstrReq=1, PC=0.
REQ-030 InstrIn=9'b000_01_10_00 with InstrValid=1 -> EXEC cycle shows WriteEn=1, Waddr=1, RaddrA=1, RaddrB=2 for one cycle; next PC=1.
REQ-031 SET 9'b001_10_1011 -> SetInst=1, WriteEn=1, Waddr=2, Imm=0x2B; LUT 9'b010_11_0101 -> LUT2x=1, Waddr=3, LutIdx=5.
REQ-032 JMP with JumpReg=0x2A: BranchTaken=1 -> next PC=0x02A; BranchTaken=0 -> PC+1.
REQ-033 PC=1023 executing a NOP -> next PC=0; HALT -> Done=1, InstrReq=0 until Start, then PC=0.
REQ-034 With FETCH_INSTR_COUNT_EN: 5 instructions then HALT -> InstrCount=6; without it, InstrCount=0.
